sdram_arbiter: RTL

Command arbiter and bus multiplexer between the SDRAM sub-controllers and the SDRAM pins. It takes the initialisation, auto-refresh, write and read stages, grants the bus to one at a time, and muxes the granted stage's command and address onto the shared outputs. It sits directly downstream of the auto-refresh stage. It latches that stage's single-cycle `aref_req`, answers with an `aref_en` pulse, and holds the bus until `ref_done`.

---
 rtl/sdram_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the SDRAM pins to the init, refresh, write and read
// stages one at a time and muxes the owner's command and address.
module sdram_arbiter #(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic        sclk,
    input  logic        snrst,
    input  logic        initial_done,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        ref_done,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic        wr_done,
    input  logic        rd_done,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        wr_brk,
    output logic        rd_brk,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr
);

    typedef enum logic [2:0] {
        IDLE,
        ARBIT,
        AREF,
        WRITE,
        READ
    } state_t;

    state_t state;
    logic   ref_pend;
    logic   last_wr;
    logic   aref_go;
    logic   wr_go;
    logic   rd_go;

    // Refresh first, then round robin on the stage not granted last.
    always_comb begin
        aref_go = (state == ARBIT) && (ref_pend || aref_req);
        wr_go   = (state == ARBIT) && !aref_go && wr_req
                  && (!rd_req || !last_wr);
        rd_go   = (state == ARBIT) && !aref_go && !wr_go && rd_req;
    end

    always_ff @(posedge sclk or negedge snrst) begin
        if (!snrst) begin
            state    <= IDLE;
            ref_pend <= 1'b0;
            last_wr  <= 1'b0;
            aref_en  <= 1'b0;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
        end else begin
            aref_en <= aref_go;
            wr_en   <= wr_go;
            rd_en   <= rd_go;

            // The request seen in the granting cycle is the one consumed.
            if (aref_go)
                ref_pend <= 1'b0;
            else if (aref_req)
                ref_pend <= 1'b1;

            if (wr_go)
                last_wr <= 1'b1;
            else if (rd_go)
                last_wr <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (initial_done)
                        state <= ARBIT;
                end
                ARBIT: begin
                    unique case (1'b1)
                        aref_go: state <= AREF;
                        wr_go:   state <= WRITE;
                        rd_go:   state <= READ;
                        default: state <= ARBIT;
                    endcase
                end
                AREF: begin
                    if (ref_done)
                        state <= ARBIT;
                end
                WRITE: begin
                    if (wr_done)
                        state <= ARBIT;
                end
                READ: begin
                    if (rd_done)
                        state <= ARBIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_brk = (state == WRITE) && ref_pend;
    assign rd_brk = (state == READ) && ref_pend;

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        unique case (state)
            IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
            end
            READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = '0;
            end
        endcase
    end

endmodule
